pipe_hazard_ctrl: RTL and testbench

- Hazard and sequencing controller for the 5-stage MIPS pipeline.
- Generates cu_stall and cu_flush for the IF/ID register and PC, plus a bubble-insert for ID/EX.
- Detects load-use hazards and branch/jump redirects, and sequences the multi-cycle mult/div unit.
- While mult/div is busy, dependent HI/LO or mult/div instructions are held in ID until completion.

---
 rtl/pipe_hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and sequencing control for the 5-stage MIPS pipeline.
// Produces the IF/ID/PC stall, the IF/ID flush and the ID/EX bubble. It detects
// load-use hazards and branch/jump redirects, and tracks the multi-cycle
// mult/div unit so that dependent HI/LO instructions are held in ID until done.
// State updates on the falling clock edge, matching the pipeline registers.
// Optional build macro PIPE_HAZARD_STATS_EN adds a 32-bit stall_cycles counter.
//
//   state      | meaning
//   ST_RUN     | no mult/div in flight
//   ST_MD_WAIT | mult/div busy, md_cnt_q counts remaining cycles down to 0
module pipe_hazard_ctrl #(
  parameter int unsigned MD_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ifid_instr,
  input  logic        idex_mem_read,
  input  logic [4:0]  idex_rt,
  input  logic        ex_redirect,
  input  logic        ex_md_start,
  output logic        cu_stall,
  output logic        cu_flush,
  output logic        idex_bubble,
  output logic        md_busy
`ifdef PIPE_HAZARD_STATS_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  typedef enum logic {ST_RUN, ST_MD_WAIT} state_t;

  localparam logic [5:0] MD_LOAD = 6'(MD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [5:0] md_cnt_q, md_cnt_d;

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       uses_rt;
  logic       md_dep;
  logic       lu;
  logic       md_hold;
  logic       unused_instr_bits;

  assign op    = ifid_instr[31:26];
  assign rs    = ifid_instr[25:21];
  assign rt    = ifid_instr[20:16];
  assign funct = ifid_instr[5:0];
  assign unused_instr_bits = ^ifid_instr[15:6];

  // Decode which source fields of the ID instruction are really read.
  always_comb begin
    uses_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) ||
              ((op >= 6'h28) && (op <= 6'h2B));
    md_dep  = (op == 6'h00) &&
              (((funct >= 6'h10) && (funct <= 6'h13)) ||
               ((funct >= 6'h18) && (funct <= 6'h1B)));
  end

  // $0 is hard-wired, so a load into it never creates a dependency.
  assign lu = idex_mem_read && (idex_rt != 5'd0) &&
              ((idex_rt == rs) || (uses_rt && (idex_rt == rt)));
  assign md_hold = (state_q == ST_MD_WAIT) && md_dep;
  assign md_busy = (state_q == ST_MD_WAIT);

  // Mult/div sequencing: a start in ST_MD_WAIT is ignored, redirects do not abort.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (ex_md_start) begin
          state_d  = ST_MD_WAIT;
          md_cnt_d = MD_LOAD;
        end
      end
      ST_MD_WAIT: begin
        if (md_cnt_q == 6'd0) begin
          state_d = ST_RUN;
        end else begin
          md_cnt_d = md_cnt_q - 6'd1;
        end
      end
      default: begin
        state_d  = ST_RUN;
        md_cnt_d = 6'd0;
      end
    endcase
  end

  // State register, falling edge like the pipeline registers.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RUN;
      md_cnt_q <= 6'd0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // Control outputs: a redirect kills the wrong-path ID instruction before any stall.
  always_comb begin
    cu_stall    = 1'b0;
    cu_flush    = 1'b0;
    idex_bubble = 1'b0;
    if (!reset) begin
      if (ex_redirect) begin
        cu_flush    = 1'b1;
        idex_bubble = 1'b1;
      end else if (lu || md_hold) begin
        cu_stall    = 1'b1;
        idex_bubble = 1'b1;
      end
    end
  end

`ifdef PIPE_HAZARD_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  // Free-running stall counter, wraps naturally at 2^32.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (cu_stall) stall_cycles_d = stall_cycles_q + 32'd1;
  end

  // Stall counter register.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) stall_cycles_q <= 32'd0;
    else       stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all compared against a behavioural model of the rules.
module tb_pipe_hazard_ctrl;
  localparam int MDC = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ifid_instr;
  logic        idex_mem_read;
  logic [4:0]  idex_rt;
  logic        ex_redirect;
  logic        ex_md_start;
  logic        cu_stall, cu_flush, idex_bubble, md_busy;
`ifdef PIPE_HAZARD_STATS_EN
  logic [31:0] stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  // model state: remaining busy cycles of the mult/div unit
  int          md_rem = 0;
  logic [31:0] stall_m = 0;

  // outputs as last sampled by cycle_check
  logic s_stall, s_flush, s_bubble, s_busy;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MD_CYCLES(MDC)) dut (
    .clk(clk), .reset(reset), .ifid_instr(ifid_instr),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
    .ex_redirect(ex_redirect), .ex_md_start(ex_md_start),
    .cu_stall(cu_stall), .cu_flush(cu_flush), .idex_bubble(idex_bubble),
    .md_busy(md_busy)
`ifdef PIPE_HAZARD_STATS_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected outputs from the hazard rules, given current inputs and model state.
  function automatic void model_out(output logic st, output logic fl, output logic bb);
    int op, rs, rt, fn;
    bit use_rt, dep, lu, hold;
    op = int'(ifid_instr >> 26);
    rs = int'(ifid_instr >> 21) % 32;
    rt = int'(ifid_instr >> 16) % 32;
    fn = int'(ifid_instr) % 64;
    use_rt = (op == 0) || (op == 4) || (op == 5) || (op >= 40 && op <= 43);
    dep = (op == 0) && ((fn >= 16 && fn <= 19) || (fn >= 24 && fn <= 27));
    lu = idex_mem_read && (int'(idex_rt) != 0) &&
         ((int'(idex_rt) == rs) || (use_rt && int'(idex_rt) == rt));
    hold = (md_rem > 0) && dep;
    st = 0; fl = 0; bb = 0;
    if (reset) return;
    if (ex_redirect) begin fl = 1; bb = 1; end
    else if (lu || hold) begin st = 1; bb = 1; end
  endfunction

  task automatic compare_now();
    logic st, fl, bb;
    model_out(st, fl, bb);
    chk("cu_stall", cu_stall, st);
    chk("cu_flush", cu_flush, fl);
    chk("idex_bubble", idex_bubble, bb);
    chk("md_busy", md_busy, md_rem > 0);
`ifdef PIPE_HAZARD_STATS_EN
    chk("stall_cycles", stall_cycles, stall_m);
`endif
    s_stall = cu_stall; s_flush = cu_flush; s_bubble = idex_bubble; s_busy = md_busy;
  endtask

  // Called right after inputs are driven at a rising edge.
  task automatic cycle_check();
    logic st, fl, bb;
    #2 compare_now();
    @(negedge clk);
    model_out(st, fl, bb);
    if (reset) begin
      md_rem = 0; stall_m = 0;
    end else begin
      if (st) stall_m = stall_m + 1;
      if (md_rem > 0) md_rem = md_rem - 1;
      else if (ex_md_start) md_rem = MDC;
    end
    @(posedge clk);
  endtask

  task automatic drive(input logic [31:0] ins, input logic mr, input logic [4:0] rt,
                       input logic rd, input logic ms);
    ifid_instr = ins; idex_mem_read = mr; idex_rt = rt; ex_redirect = rd; ex_md_start = ms;
  endtask

  function automatic logic [31:0] rand_instr();
    int sel;
    logic [5:0] op, fn;
    logic [5:0] ops [7];
    logic [5:0] fns [8];
    ops = '{6'h00, 6'h04, 6'h05, 6'h23, 6'h2B, 6'h08, 6'h02};
    fns = '{6'h20, 6'h10, 6'h12, 6'h11, 6'h13, 6'h18, 6'h1B, 6'h2A};
    sel = $urandom_range(0, 6);
    op = ops[sel];
    fn = fns[$urandom_range(0, 7)];
    return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            10'($urandom), fn};
  endfunction

  int stall_n;

  initial begin
    reset = 1'b1;
    drive(32'h00652020, 1'b1, 5'd3, 1'b0, 1'b0);
    #2;
    chk("reset_stall", cu_stall, 0);
    chk("reset_bubble", idex_bubble, 0);
    chk("reset_busy", md_busy, 0);
    @(posedge clk);
    @(posedge clk);
    reset = 1'b0;
    md_rem = 0; stall_m = 0;

    // load-use: lw $3 in EX, add $4,$3,$5 in ID -> one stall, then bubble clears it
    drive(32'h00652020, 1'b1, 5'd3, 1'b0, 1'b0);
    cycle_check();
    chk("lu_stall", s_stall, 1); chk("lu_bubble", s_bubble, 1);
    drive(32'h00652020, 1'b0, 5'd0, 1'b0, 1'b0);
    cycle_check();
    chk("lu_release", s_stall, 0);

    // $0 target and an instruction that does not read rt
    drive(32'h00052020, 1'b1, 5'd0, 1'b0, 1'b0);
    cycle_check();
    chk("lu_r0", s_stall, 0);
    drive(32'h20C30001, 1'b1, 5'd3, 1'b0, 1'b0);
    cycle_check();
    chk("lu_addi_rt", s_stall, 0);

    // redirect overrides load-use
    drive(32'h00652020, 1'b1, 5'd3, 1'b1, 1'b0);
    cycle_check();
    chk("redir_flush", s_flush, 1); chk("redir_bubble", s_bubble, 1);
    chk("redir_stall", s_stall, 0);

    // mult/div issue, then mflo waits exactly MDC cycles
    drive(32'h00000000, 1'b0, 5'd0, 1'b0, 1'b1);
    cycle_check();
    drive(32'h00001012, 1'b0, 5'd0, 1'b0, 1'b0);
    stall_n = 0;
    for (int i = 0; i < 100; i++) begin
      cycle_check();
      if (!s_stall) break;
      stall_n++;
    end
    chk("mflo_stall_len", stall_n, MDC);
    chk("mflo_busy_after", s_busy, 0);

    // unrelated add during a busy period proceeds
    drive(32'h00000000, 1'b0, 5'd0, 1'b0, 1'b1);
    cycle_check();
    drive(32'h00652020, 1'b0, 5'd0, 1'b0, 1'b0);
    cycle_check();
    chk("add_busy", s_busy, 1); chk("add_nostall", s_stall, 0);

    // reset in the middle of the busy period, with a load-use condition present
    for (int i = 0; i < 19; i++) cycle_check();
    drive(32'h00651012 | 32'h0, 1'b1, 5'd3, 1'b0, 1'b0);
    #1 reset = 1'b1;
    md_rem = 0; stall_m = 0;
    #1;
    chk("rst_mid_busy", md_busy, 0);
    chk("rst_mid_stall", cu_stall, 0);
    chk("rst_mid_bubble", idex_bubble, 0);
    @(posedge clk);
    reset = 1'b0;
    drive(32'h00001012, 1'b0, 5'd0, 1'b0, 1'b0);
    cycle_check();
    chk("rst_run_mflo", s_stall, 0);
    chk("rst_run_busy", s_busy, 0);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      drive(rand_instr(), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 9) == 0));
      cycle_check();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
